// File: rtl/board_game_engine.sv
// board_game_engine: N x N, K-in-a-row turn referee.
// Accepts moves, flags bad ones, then judges win/draw.
module board_game_engine #(
  parameter int N = 3,
  parameter int K = 3,
  parameter int FIRST = 0,
  localparam int CW = $clog2(N*N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_game,
  input  logic              move_valid,
  input  logic              move_who,
  input  logic [CW-1:0]     move_idx,
  output logic              move_ready,
  output logic [2*N*N-1:0]  board,
  output logic [1:0]        winner,
  output logic              turn,
  output logic [CW:0]       move_count,
  output logic              err_illegal,
  output logic              err_turn
);

  localparam int NC = N*N;
  localparam logic [1:0] W_DRAW = 2'd0;
  localparam logic [1:0] W_PLR  = 2'd1;
  localparam logic [1:0] W_CMP  = 2'd2;
  localparam logic [1:0] W_CONT = 2'd3;

  typedef enum logic [1:0] {
    PLAY,
    CHECK,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2*NC-1:0]   board_q, board_d;
  logic [1:0]        winner_q, winner_d;
  logic              turn_q, turn_d;
  logic [CW:0]       count_q, count_d;
  logic              ei_q, ei_d;
  logic              et_q, et_d;
  logic              occ;
  logic              in_range;
  logic              p_run;
  logic              c_run;

  // True when some K-long line of the board is all `code`.
  function automatic logic has_run(
    input logic [2*NC-1:0] b,
    input logic [1:0]      code
  );
    logic hit;
    logic ok;
    hit = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (c + K <= N) begin
          ok = 1'b1;
          for (int i = 0; i < K; i++)
            if (b[2*(r*N+c+i) +: 2] != code) ok = 1'b0;
          hit = hit | ok;
        end
        if (r + K <= N) begin
          ok = 1'b1;
          for (int i = 0; i < K; i++)
            if (b[2*((r+i)*N+c) +: 2] != code) ok = 1'b0;
          hit = hit | ok;
        end
        if (r + K <= N && c + K <= N) begin
          ok = 1'b1;
          for (int i = 0; i < K; i++)
            if (b[2*((r+i)*N+c+i) +: 2] != code) ok = 1'b0;
          hit = hit | ok;
        end
        if (r + K <= N && c >= K - 1) begin
          ok = 1'b1;
          for (int i = 0; i < K; i++)
            if (b[2*((r+i)*N+c-i) +: 2] != code) ok = 1'b0;
          hit = hit | ok;
        end
      end
    end
    return hit;
  endfunction

  // Target-cell lookup and range test for the offered move.
  always_comb begin
    occ = 1'b0;
    for (int i = 0; i < NC; i++)
      if (move_idx == CW'(i))
        occ = (board_q[2*i +: 2] != 2'b00);
    in_range = ({1'b0, move_idx} < (CW+1)'(NC));
  end

  // Line detection on the registered board for both sides.
  always_comb begin
    p_run = has_run(board_q, W_PLR);
    c_run = has_run(board_q, W_CMP);
  end

  // Next-state and next-register logic of the game FSM.
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    winner_d = winner_q;
    turn_d   = turn_q;
    count_d  = count_q;
    ei_d     = 1'b0;
    et_d     = 1'b0;
    if (new_game) begin
      state_d  = PLAY;
      board_d  = '0;
      winner_d = W_CONT;
      turn_d   = 1'(FIRST);
      count_d  = '0;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (move_valid) begin
            if (move_who != turn_q) begin
              et_d = 1'b1;
            end else if (!in_range || occ) begin
              ei_d = 1'b1;
            end else begin
              for (int i = 0; i < NC; i++)
                if (move_idx == CW'(i))
                  board_d[2*i +: 2] = move_who ? W_CMP : W_PLR;
              count_d = count_q + 1'b1;
              turn_d  = ~turn_q;
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          if (p_run) begin
            winner_d = W_PLR;
            state_d  = DONE;
          end else if (c_run) begin
            winner_d = W_CMP;
            state_d  = DONE;
          end else if (count_q == (CW+1)'(NC)) begin
            winner_d = W_DRAW;
            state_d  = DONE;
          end else begin
            winner_d = W_CONT;
            state_d  = PLAY;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = PLAY;
        end
      endcase
    end
  end

  // State and game registers, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= PLAY;
      board_q  <= '0;
      winner_q <= W_CONT;
      turn_q   <= 1'(FIRST);
      count_q  <= '0;
      ei_q     <= 1'b0;
      et_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      winner_q <= winner_d;
      turn_q   <= turn_d;
      count_q  <= count_d;
      ei_q     <= ei_d;
      et_q     <= et_d;
    end
  end

  assign move_ready  = (state_q == PLAY) && !new_game;
  assign board       = board_q;
  assign winner      = winner_q;
  assign turn        = turn_q;
  assign move_count  = count_q;
  assign err_illegal = ei_q;
  assign err_turn    = et_q;

endmodule

// File: tb/tb_board_game_engine.sv
// tb_board_game_engine: two engines (3x3 K3, 5x5 K4)
// checked every cycle against a cell-array game model.
module tb_board_game_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ng [2];
  logic mv [2];
  logic who [2];
  logic [3:0] idx0;
  logic [4:0] idx1;

  logic        rdy0, turn0, ei0, et0;
  logic [17:0] board0;
  logic [1:0]  win0;
  logic [4:0]  cnt0;
  logic        rdy1, turn1, ei1, et1;
  logic [49:0] board1;
  logic [1:0]  win1;
  logic [5:0]  cnt1;

  int n_chk = 0;
  int n_fail = 0;

  int cells [2][25];
  int mturn [2];
  int mcnt [2];
  int mwin [2];
  int mph [2];
  bit mei [2];
  bit met [2];

  always #5 clk = ~clk;

  board_game_engine #(.N(3), .K(3), .FIRST(0)) dut0 (
    .clk(clk), .reset(reset), .new_game(ng[0]),
    .move_valid(mv[0]), .move_who(who[0]),
    .move_idx(idx0), .move_ready(rdy0),
    .board(board0), .winner(win0), .turn(turn0),
    .move_count(cnt0), .err_illegal(ei0),
    .err_turn(et0)
  );

  board_game_engine #(.N(5), .K(4), .FIRST(0)) dut1 (
    .clk(clk), .reset(reset), .new_game(ng[1]),
    .move_valid(mv[1]), .move_who(who[1]),
    .move_idx(idx1), .move_ready(rdy1),
    .board(board1), .winner(win1), .turn(turn1),
    .move_count(cnt1), .err_illegal(ei1),
    .err_turn(et1)
  );

  function automatic int nsz(int j);
    return (j == 0) ? 3 : 5;
  endfunction

  function automatic int ksz(int j);
    return (j == 0) ? 3 : 4;
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // walk each line from every cell; any run >= k wins
  function automatic bit has_line(int j, int code);
    int n, k, len, rr, cc;
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    n = nsz(j);
    k = ksz(j);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          len = 0;
          rr = r;
          cc = c;
          while (rr >= 0 && rr < n && cc >= 0 && cc < n
                 && cells[j][rr*n+cc] == code) begin
            len++;
            rr += dr[d];
            cc += dc[d];
          end
          if (len >= k) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic minit(int j);
    for (int c = 0; c < 25; c++) cells[j][c] = 0;
    mturn[j] = 0;
    mcnt[j] = 0;
    mwin[j] = 3;
    mph[j] = 0;
    mei[j] = 1'b0;
    met[j] = 1'b0;
  endtask

  task automatic mstep(int j);
    int n, i;
    n = nsz(j);
    i = (j == 0) ? int'(idx0) : int'(idx1);
    mei[j] = 1'b0;
    met[j] = 1'b0;
    if (ng[j]) begin
      minit(j);
    end else if (mph[j] == 1) begin
      mph[j] = 2;
      if (has_line(j, 1)) mwin[j] = 1;
      else if (has_line(j, 2)) mwin[j] = 2;
      else if (mcnt[j] == n*n) mwin[j] = 0;
      else begin
        mwin[j] = 3;
        mph[j] = 0;
      end
    end else if (mph[j] == 0 && mv[j]) begin
      if (int'(who[j]) != mturn[j]) met[j] = 1'b1;
      else if (i >= n*n) mei[j] = 1'b1;
      else if (cells[j][i] != 0) mei[j] = 1'b1;
      else begin
        cells[j][i] = mturn[j] + 1;
        mcnt[j]++;
        mturn[j] = 1 - mturn[j];
        mph[j] = 1;
      end
    end
  endtask

  // reference model
  initial begin
    minit(0);
    minit(1);
    forever begin
      @(posedge clk or posedge reset);
      for (int j = 0; j < 2; j++)
        if (reset) minit(j);
        else mstep(j);
    end
  end

  // per-cycle compare of both engines against the model
  initial begin
    logic [63:0] eb;
    forever begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 2; j++) begin
        eb = '0;
        for (int c = 0; c < nsz(j)*nsz(j); c++)
          eb[2*c +: 2] = 2'(cells[j][c]);
        chk($sformatf("dut%0d.ready", j),
            64'(j == 0 ? rdy0 : rdy1),
            64'(mph[j] == 0 && !ng[j]));
        chk($sformatf("dut%0d.board", j),
            (j == 0) ? 64'(board0) : 64'(board1), eb);
        chk($sformatf("dut%0d.winner", j),
            64'(j == 0 ? win0 : win1), 64'(mwin[j]));
        chk($sformatf("dut%0d.turn", j),
            64'(j == 0 ? turn0 : turn1), 64'(mturn[j]));
        chk($sformatf("dut%0d.count", j),
            (j == 0) ? 64'(cnt0) : 64'(cnt1),
            64'(mcnt[j]));
        chk($sformatf("dut%0d.err_illegal", j),
            64'(j == 0 ? ei0 : ei1), 64'(mei[j]));
        chk($sformatf("dut%0d.err_turn", j),
            64'(j == 0 ? et0 : et1), 64'(met[j]));
      end
    end
  end

  task automatic setidx(int j, int i);
    if (j == 0) idx0 = 4'(i);
    else idx1 = 5'(i);
  endtask

  task automatic offer(int j, bit w, int i);
    @(negedge clk);
    mv[j] = 1'b1;
    who[j] = w;
    setidx(j, i);
    @(negedge clk);
    mv[j] = 1'b0;
  endtask

  task automatic newg(int j);
    @(negedge clk);
    ng[j] = 1'b1;
    @(negedge clk);
    ng[j] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int ad [8] = '{0, 4, 1, 8, 2, 12, 24, 16};
    for (int j = 0; j < 2; j++) begin
      ng[j] = 1'b0;
      mv[j] = 1'b0;
      who[j] = 1'b0;
    end
    idx0 = '0;
    idx1 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst.winner", 64'(win0), 64'd3);
    chk("rst.count", 64'(cnt0), 64'd0);
    chk("rst.ready", 64'(rdy0), 64'd1);

    // player row 0 win on the fifth move
    offer(0, 0, 0);
    offer(0, 1, 3);
    offer(0, 0, 1);
    offer(0, 1, 4);
    offer(0, 0, 2);
    chk("win.latency", 64'(win0), 64'd3);
    @(negedge clk);
    chk("win.winner", 64'(win0), 64'd1);
    chk("win.count", 64'(cnt0), 64'd5);
    offer(0, 1, 5);
    chk("done.count", 64'(cnt0), 64'd5);
    chk("done.board", 64'(board0), 64'h295);
    chk("done.err", 64'({ei0, et0}), 64'd0);

    // full board, no line
    newg(0);
    chk("ng.board", 64'(board0), 64'd0);
    chk("ng.winner", 64'(win0), 64'd3);
    for (int m = 0; m < 9; m++)
      offer(0, m[0], seq[m]);
    @(negedge clk);
    chk("draw.winner", 64'(win0), 64'd0);
    chk("draw.count", 64'(cnt0), 64'd9);
    chk("draw.ready", 64'(rdy0), 64'd0);

    // occupied cell, out of turn, out of range
    newg(0);
    offer(0, 0, 4);
    offer(0, 1, 4);
    chk("occ.ei", 64'(ei0), 64'd1);
    chk("occ.et", 64'(et0), 64'd0);
    chk("occ.turn", 64'(turn0), 64'd1);
    chk("occ.cell", 64'(board0[9:8]), 64'd1);
    @(negedge clk);
    chk("occ.pulse", 64'(ei0), 64'd0);
    offer(0, 0, 0);
    chk("oot.et", 64'(et0), 64'd1);
    chk("oot.ei", 64'(ei0), 64'd0);
    offer(0, 1, 9);
    chk("oor9.ei", 64'(ei0), 64'd1);
    offer(0, 1, 15);
    chk("oor15.ei", 64'(ei0), 64'd1);

    // reset while in CHECK
    offer(0, 1, 0);
    reset = 1'b1;
    #1;
    chk("rstchk.board", 64'(board0), 64'd0);
    chk("rstchk.winner", 64'(win0), 64'd3);
    chk("rstchk.count", 64'(cnt0), 64'd0);
    chk("rstchk.turn", 64'(turn0), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    offer(0, 0, 8);
    chk("rstchk.next", 64'(cnt0), 64'd1);

    // 5x5 K4: computer anti-diagonal 4,8,12,16
    for (int m = 0; m < 5; m++)
      offer(1, m[0], ad[m]);
    @(negedge clk);
    chk("run3.winner", 64'(win1), 64'd3);
    for (int m = 5; m < 8; m++)
      offer(1, m[0], ad[m]);
    @(negedge clk);
    chk("adiag.winner", 64'(win1), 64'd2);
    chk("adiag.count", 64'(cnt1), 64'd8);

    // randomized play on both engines
    repeat (3000) begin
      @(negedge clk);
      reset = ($urandom_range(0, 999) < 3);
      for (int j = 0; j < 2; j++) begin
        ng[j] = ($urandom_range(0, 99) < 1);
        mv[j] = ($urandom_range(0, 99) < 60);
        who[j] = ($urandom_range(0, 3) == 0)
                 ? ~mturn[j][0] : mturn[j][0];
      end
      idx0 = 4'($urandom_range(0, 9));
      idx1 = 5'($urandom_range(0, 26));
    end
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 2; j++) begin
      ng[j] = 1'b0;
      mv[j] = 1'b0;
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/board_game_engine.md
BOARD_GAME_ENGINE -- requirements
Module: board_game_engine

Interface
REQ-001 Parameter N, default 3, board edge length; legal range 3..8.
REQ-002 Parameter K, default 3, marks-in-a-row needed to win; legal range 3..N.
REQ-003 Parameter FIRST, default 0, side that moves first after reset or new game (0 player, 1 computer).
REQ-004 Derived constant CW = clog2(N*N) SHALL size move_idx and move_count.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 new_game  in  1  synchronous restart request.
REQ-008 move_valid  in  1  move offered this cycle.
REQ-009 move_who  in  1  mover identity (0 player, 1 computer).
REQ-010 move_idx  in  CW  cell index, row-major, cell = row*N+col.
REQ-011 move_ready  out  1  engine accepts a move this cycle.
REQ-012 board  out  2*N*N  cell c at bits [2c+1:2c]; 00 empty, 01 player, 10 computer.
REQ-013 winner  out  2  0 draw, 1 player win, 2 computer win, 3 game continuing.
REQ-014 turn  out  1  side expected to move next.
REQ-015 move_count  out  CW+1  number of accepted moves.
REQ-016 err_illegal  out  1  one-cycle pulse on rejected occupied/out-of-range move.
REQ-017 err_turn  out  1  one-cycle pulse on rejected out-of-turn move.

Function
REQ-018 FSM states SHALL be PLAY, CHECK, DONE.
REQ-019 move_ready SHALL be 1 only in PLAY with new_game low.
REQ-020 Handshake: a move is presented when move_valid & move_ready at a rising edge.
REQ-021 Presented move with move_who != turn SHALL be rejected: err_turn=1 next cycle, board/turn/count unchanged, state stays PLAY.
REQ-022 Presented in-turn move with move_idx >= N*N or target cell non-empty SHALL be rejected: err_illegal=1 next cycle, nothing else changes; err_turn has priority, never both set.
REQ-023 Accepted move SHALL write the mover's code into the cell, increment move_count, toggle turn, and enter CHECK, all on the same edge.
REQ-024 CHECK SHALL last exactly one cycle, evaluating every horizontal, vertical, diagonal and anti-diagonal K-long window of the registered board.
REQ-025 On leaving CHECK: K-run for player -> winner=1, DONE; K-run for computer -> winner=2, DONE; else board full (move_count=N*N) -> winner=0, DONE; else winner=3, PLAY.
REQ-026 A win on the move that fills the board SHALL report the win, not a draw.
REQ-027 winner SHALL update at the edge ending CHECK: acceptance edge + 1 cycle latency; next move accepted no earlier than acceptance edge + 2.
REQ-028 In CHECK and DONE, move_valid SHALL be ignored; no error pulse, no state change.
REQ-029 new_game high at an edge, in any state, SHALL clear board, move_count=0, winner=3, turn=FIRST, errors 0, state PLAY; it overrides a simultaneous move.
REQ-030 move_valid asserted without acceptance SHALL leave move_valid/move_idx free to change; no holding requirement on the source.
REQ-031 err_illegal and err_turn SHALL be registered and high for exactly one cycle per rejected move.

Reset
REQ-032 reset high SHALL immediately force: board all 00, winner=3, turn=FIRST, move_count=0, err_illegal=0, err_turn=0, state PLAY.
REQ-033 Reset asserted mid-CHECK or in DONE SHALL abort the game; the first edge after deassertion SHALL act as PLAY with move_ready=1.

Verification
REQ-034 N=3,K=3,FIRST=0: player 0, comp 3, player 1, comp 4, player 2 -> winner=1 one cycle after the 5th acceptance; further moves ignored, move_count=5.
REQ-035 N=3: nine alternating moves 0,1,2,4,3,5,7,6,8 with no line -> winner=0, move_count=9, state DONE.
REQ-036 Player takes cell 4, computer offers cell 4 -> err_illegal pulse, turn stays 1, board[9:8]=01; then player offers a move out of turn -> err_turn only.
REQ-037 N=5,K=4: computer completes anti-diagonal 4,8,12,16 -> winner=2; a 3-long run never wins.
REQ-038 Assert reset during CHECK and new_game in DONE -> all outputs at reset values, next move accepted.
